pc_sequencer: RTL and testbench

Registered program-counter unit for the 16-bit CPU fetch stage. It replaces the combinational next-PC selector with a parametrised sequencer that holds the PC and evaluates all sixteen condition codes against the PSR flags. It supports absolute jumps, signed relative branches, jump-and-link, and return through a small hardware return-address stack (RAS). It drives the instruction-memory address and the link-register write port of the register file.

---
 rtl/pc_seq_pkg.sv | 42 ++++
 rtl/pc_cond_eval.sv | 42 ++++
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the fetch-stage PC sequencer: instruction kinds,
// condition codes and PSR flag bit positions.
package pc_seq_pkg;

    localparam int unsigned KIND_W  = 3;
    localparam int unsigned COND_W  = 4;
    localparam int unsigned FLAGS_W = 5;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 4;

    typedef enum logic [KIND_W-1:0] {
        KIND_SEQ   = 3'b000,
        KIND_JCOND = 3'b001,
        KIND_BCOND = 3'b010,
        KIND_JAL   = 3'b011,
        KIND_RET   = 3'b100
    } kind_e;

    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_HI = 4'b0100,
        COND_LS = 4'b0101,
        COND_GT = 4'b0110,
        COND_LE = 4'b0111,
        COND_FS = 4'b1000,
        COND_FC = 4'b1001,
        COND_LO = 4'b1010,
        COND_HS = 4'b1011,
        COND_LT = 4'b1100,
        COND_GE = 4'b1101,
        COND_UC = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/pc_cond_eval.sv
// Combinational condition-code evaluator against the PSR flags; shared with
// the predicated-execution logic.
module pc_cond_eval
    import pc_seq_pkg::*;
(
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               cond_true
);

    logic c_f, l_f, f_f, z_f, n_f;

    assign c_f = flags[FLAG_C];
    assign l_f = flags[FLAG_L];
    assign f_f = flags[FLAG_F];
    assign z_f = flags[FLAG_Z];
    assign n_f = flags[FLAG_N];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = z_f;
            COND_NE: cond_true = !z_f;
            COND_CS: cond_true = c_f;
            COND_CC: cond_true = !c_f;
            COND_HI: cond_true = l_f;
            COND_LS: cond_true = !l_f;
            COND_GT: cond_true = n_f;
            COND_LE: cond_true = !n_f;
            COND_FS: cond_true = f_f;
            COND_FC: cond_true = !f_f;
            COND_LO: cond_true = !l_f && !z_f;
            COND_HS: cond_true = l_f || z_f;
            COND_LT: cond_true = !n_f && !z_f;
            COND_GE: cond_true = n_f || z_f;
            COND_UC: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with conditional jumps/branches, jump-and-link
// and a circular hardware return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     PC_W      = 16,
    parameter int unsigned     DISP_W    = 8,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [KIND_W-1:0]  kind,
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] flags,
    input  logic [PC_W-1:0]    target,
    input  logic [DISP_W-1:0]  disp,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_next,
    output logic               taken,
    output logic               link_we,
    output logic [PC_W-1:0]    link_data,
    output logic               ras_ovf,
    output logic               ras_unf
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_top;
    logic [CNT_W-1:0] ras_cnt;
    logic [PTR_W-1:0] push_ptr;
    logic             ras_empty;
    logic             ras_full;

    logic             cond_true;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  disp_ext;
    logic             redirect;
    logic             do_push;
    logic             do_pop;
    logic             unf_hit;

    pc_cond_eval u_cond_eval (
        .cond      (cond),
        .flags     (flags),
        .cond_true (cond_true)
    );

    assign pc_inc    = pc + PC_W'(1);
    assign disp_ext  = {{(PC_W - DISP_W){disp[DISP_W-1]}}, disp};
    assign push_ptr  = ras_top + PTR_W'(1);
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));

    // Next-PC select; taken only when a redirect actually departs from pc+1.
    always_comb begin
        pc_next  = pc_inc;
        redirect = 1'b0;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        unf_hit  = 1'b0;
        case (kind)
            KIND_JCOND: begin
                if (cond_true) begin
                    pc_next  = target;
                    redirect = 1'b1;
                end
            end
            KIND_BCOND: begin
                if (cond_true) begin
                    pc_next  = pc + disp_ext;
                    redirect = 1'b1;
                end
            end
            KIND_JAL: begin
                pc_next  = target;
                redirect = 1'b1;
                do_push  = 1'b1;
            end
            KIND_RET: begin
                if (!ras_empty) begin
                    pc_next  = ras_mem[ras_top];
                    redirect = 1'b1;
                    do_pop   = 1'b1;
                end else begin
                    unf_hit = 1'b1;
                end
            end
            default: ;
        endcase
        taken = redirect && (pc_next != pc_inc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            ras_top   <= '0;
            ras_cnt   <= '0;
            link_we   <= 1'b0;
            link_data <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else begin
            link_we <= 1'b0;
            if (en) begin
                pc <= pc_next;
                if (do_push) begin
                    ras_top   <= push_ptr;
                    link_we   <= 1'b1;
                    link_data <= pc_inc;
                    if (ras_full) begin
                        ras_ovf <= 1'b1;
                    end else begin
                        ras_cnt <= ras_cnt + CNT_W'(1);
                    end
                end
                if (do_pop) begin
                    ras_top <= ras_top - PTR_W'(1);
                    ras_cnt <= ras_cnt - CNT_W'(1);
                end
                if (unf_hit) begin
                    ras_unf <= 1'b1;
                end
            end
        end
    end

    // Stack storage needs no reset; liveness is tracked by ras_cnt.
    always_ff @(posedge clk) begin
        if (!reset && en && do_push) begin
            ras_mem[push_ptr] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a reference model predicts each cycle's
// combinational and registered outputs, which are queued and compared.
module tb_pc_sequencer;

    localparam logic [15:0] RST_PC = 16'h0100;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  kind;
    logic [3:0]  cond;
    logic [4:0]  flags;
    logic [15:0] target;
    logic [7:0]  disp;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic        taken;
    logic        link_we;
    logic [15:0] link_data;
    logic        ras_ovf;
    logic        ras_unf;

    pc_sequencer #(
        .PC_W      (16),
        .DISP_W    (8),
        .RAS_DEPTH (4),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .kind      (kind),
        .cond      (cond),
        .flags     (flags),
        .target    (target),
        .disp      (disp),
        .pc        (pc),
        .pc_next   (pc_next),
        .taken     (taken),
        .link_we   (link_we),
        .link_data (link_data),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        lwe;
        logic [15:0] ldata;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;

    logic [15:0] m_pc;
    logic [15:0] m_ras[$];
    logic        m_lwe;
    logic [15:0] m_ldata;
    logic        m_ovf;
    logic        m_unf;
    logic        m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [4:0] f);
        logic cf, lf, ff, zf, nf;
        cf = f[0]; lf = f[1]; ff = f[2]; zf = f[3]; nf = f[4];
        case (c)
            4'd0:  return zf;
            4'd1:  return !zf;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return lf;
            4'd5:  return !lf;
            4'd6:  return nf;
            4'd7:  return !nf;
            4'd8:  return ff;
            4'd9:  return !ff;
            4'd10: return !lf && !zf;
            4'd11: return lf || zf;
            4'd12: return !nf && !zf;
            4'd13: return nf || zf;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One clock of stimulus: predict, check combinational outputs, then registered ones.
    task automatic step(input logic e, input logic [2:0] k, input logic [3:0] c,
                        input logic [4:0] f, input logic [15:0] t, input logic [7:0] d,
                        input logic rst);
        logic [15:0] inc;
        logic [15:0] nxt;
        logic        red;
        exp_t        ex;
        exp_t        ob;
        @(negedge clk);
        reset = rst; en = e; kind = k; cond = c; flags = f; target = t; disp = d;
        #1;
        inc = m_pc + 16'd1;
        nxt = inc;
        red = 1'b0;
        case (k)
            3'd1: if (ref_cond(c, f)) begin nxt = t; red = 1'b1; end
            3'd2: if (ref_cond(c, f)) begin nxt = m_pc + {{8{d[7]}}, d}; red = 1'b1; end
            3'd3: begin nxt = t; red = 1'b1; end
            3'd4: if (m_ras.size() > 0) begin nxt = m_ras[$]; red = 1'b1; end
            default: ;
        endcase
        if (m_valid) begin
            chk("pc_next", 32'(pc_next), 32'(nxt));
            chk("taken", 32'(taken), 32'(red && (nxt != inc)));
        end
        if (rst) begin
            m_pc = RST_PC; m_ras.delete(); m_lwe = 1'b0; m_ldata = '0;
            m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b1;
        end else if (e) begin
            m_pc  = nxt;
            m_lwe = (k == 3'd3);
            if (k == 3'd3) begin
                m_ldata = inc;
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(inc);
            end
            if (k == 3'd4) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
                else m_unf = 1'b1;
            end
        end else begin
            m_lwe = 1'b0;
        end
        ex.pc = m_pc; ex.lwe = m_lwe; ex.ldata = m_ldata; ex.ovf = m_ovf; ex.unf = m_unf;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        ob = exp_q.pop_front();
        chk("pc", 32'(pc), 32'(ob.pc));
        chk("link_we", 32'(link_we), 32'(ob.lwe));
        chk("link_data", 32'(link_data), 32'(ob.ldata));
        chk("ras_ovf", 32'(ras_ovf), 32'(ob.ovf));
        chk("ras_unf", 32'(ras_unf), 32'(ob.unf));
    endtask

    task automatic go(input logic [15:0] a);
        step(1'b1, 3'd1, 4'd14, 5'd0, a, 8'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; kind = '0; cond = '0; flags = '0; target = '0; disp = '0;
        m_pc = '0; m_lwe = 1'b0; m_ldata = '0; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset then three sequential fetches.
        step(1'b0, 3'd0, 4'd0, 5'd0, 16'h0, 8'd0, 1'b1);
        chk("reset_pc", 32'(pc), 32'h0100);
        repeat (3) step(1'b1, 3'd0, 4'd0, 5'd0, 16'h0, 8'd0, 1'b0);
        chk("seq3_pc", 32'(pc), 32'h0103);

        // Backward branch taken / not taken.
        go(16'h0010);
        step(1'b1, 3'd2, 4'd0, 5'b01000, 16'h0, 8'hFC, 1'b0);
        chk("bcond_taken_pc", 32'(pc), 32'h000C);
        go(16'h0010);
        step(1'b1, 3'd2, 4'd0, 5'b00000, 16'h0, 8'hFC, 1'b0);
        chk("bcond_fall_pc", 32'(pc), 32'h0011);

        // Full condition-code sweep.
        for (int c = 0; c < 16; c++)
            for (int f = 0; f < 32; f++)
                step(1'b1, 3'd1, 4'(c), 5'(f), 16'hBEEF, 8'd0, 1'b0);

        // Jump-and-link followed by return.
        go(16'h0020);
        step(1'b1, 3'd3, 4'd0, 5'd0, 16'h0400, 8'd0, 1'b0);
        chk("jal_pc", 32'(pc), 32'h0400);
        chk("jal_link", 32'(link_data), 32'h0021);
        step(1'b1, 3'd4, 4'd0, 5'd0, 16'h0, 8'd0, 1'b0);
        chk("ret_pc", 32'(pc), 32'h0021);

        // Stack overflow and underflow.
        for (int i = 0; i < 5; i++)
            step(1'b1, 3'd3, 4'd0, 5'd0, 16'h1000 + 16'(i * 16), 8'd0, 1'b0);
        chk("ovf_after5", 32'(ras_ovf), 32'd1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 3'd4, 4'd0, 5'd0, 16'h0, 8'd0, 1'b0);
        chk("unf_after5", 32'(ras_unf), 32'd1);

        // Wrap, hold and reset during a JAL.
        go(16'hFFFF);
        step(1'b1, 3'd0, 4'd0, 5'd0, 16'h0, 8'd0, 1'b0);
        chk("wrap_pc", 32'(pc), 32'h0000);
        step(1'b1, 3'd3, 4'd0, 5'd0, 16'h0700, 8'd0, 1'b0);
        repeat (3) step(1'b0, 3'd3, 4'd0, 5'd0, 16'h0900, 8'd0, 1'b0);
        chk("hold_pc", 32'(pc), 32'h0700);
        step(1'b1, 3'd3, 4'd0, 5'd0, 16'h0A00, 8'd0, 1'b1);
        chk("rst_jal_pc", 32'(pc), 32'h0100);
        step(1'b1, 3'd4, 4'd0, 5'd0, 16'h0, 8'd0, 1'b0);
        chk("rst_ras_empty", 32'(pc), 32'h0101);

        // Random mix, including the unused kind encodings.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), 4'($urandom),
                 5'($urandom), 16'($urandom), 8'($urandom), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
